// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: digit width, decimal
// correction constant, controller states and the tens-detect function.
package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [4:0] BCD_CORR = 5'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A raw digit sum of 10..19 needs decimal correction. The OR of these
    // three terms catches exactly that range and also flags the nibble
    // patterns 0xA..0xF.
    function automatic logic bcd_tens(input logic [4:0] bin);
        return bin[4] | (bin[3] & bin[2]) | (bin[3] & bin[1]);
    endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// Single-digit BCD add with decimal correction. The fault input inverts the
// tens decision, modelling a faulty correction majority gate.
module bcd_digit_correct
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_d,
    input  logic [BCD_W-1:0] b_d,
    input  logic             cin,
    input  logic             fault,
    output logic [BCD_W-1:0] sum_d,
    output logic             tens_out
);

    logic [4:0] bin;
    logic [4:0] corr;
    logic       tf;

    always_comb begin
        bin   = {1'b0, a_d} + {1'b0, b_d} + {4'd0, cin};
        corr  = bin + BCD_CORR;
        tf    = bcd_tens(bin) ^ fault;
        sum_d = tf ? corr[3:0] : bin[3:0];
    end

    assign tens_out = tf;

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock through a shared
// correction stage, with operands and fault mask latched at start.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    input  logic                    cin,
    input  logic [DIGITS-1:0]       fault_mask,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    invalid
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OP_W  = BCD_W * DIGITS;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic [OP_W-1:0]       a_q, a_d;
    logic [OP_W-1:0]       b_q, b_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic [OP_W-1:0]       sum_q, sum_d;
    logic                  cout_q, cout_d;
    logic                  invalid_q, invalid_d;

    logic [BCD_W-1:0]      dig_a;
    logic [BCD_W-1:0]      dig_b;
    logic                  dig_fault;
    logic [BCD_W-1:0]      dig_sum;
    logic                  dig_tens;
    logic                  in_invalid;

    assign dig_a     = a_q[int'(idx_q)*BCD_W +: BCD_W];
    assign dig_b     = b_q[int'(idx_q)*BCD_W +: BCD_W];
    assign dig_fault = mask_q[idx_q];

    bcd_digit_correct u_digit (
        .a_d      (dig_a),
        .b_d      (dig_b),
        .cin      (carry_q),
        .fault    (dig_fault),
        .sum_d    (dig_sum),
        .tens_out (dig_tens)
    );

    always_comb begin
        in_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*BCD_W +: BCD_W] > 4'd9 || b[i*BCD_W +: BCD_W] > 4'd9)
                in_invalid = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        mask_d    = mask_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    mask_d    = fault_mask;
                    carry_d   = cin;
                    idx_d     = '0;
                    sum_d     = '0;
                    cout_d    = 1'b0;
                    invalid_d = in_invalid;
                    state_d   = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*BCD_W +: BCD_W] = dig_sum;
                carry_d = dig_tens;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    cout_d  = dig_tens;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mask_q    <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mask_q    <= mask_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder with DIGITS=4.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic [DIGITS-1:0]     fault_mask;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .fault_mask (fault_mask),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .cout       (cout),
        .invalid    (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full operation: start at edge k, RUN for DIGITS edges, done after
    // edge k+DIGITS, results held one cycle later. Inputs are scrambled after
    // the start edge so the latched copies must be used.
    task automatic run_op(input string tag,
                          input logic [15:0] a_v, input logic [15:0] b_v,
                          input logic ci, input logic [3:0] m,
                          input logic [15:0] es, input logic ec, input logic ei,
                          input bit poke_start);
        int cnt0;
        @(negedge clk);
        a = a_v; b = b_v; cin = ci; fault_mask = m; start = 1'b1;
        @(posedge clk); #1;
        cnt0 = done_cnt;
        start = 1'b0;
        a = 16'hFFFF; b = 16'hABCD; cin = ~ci; fault_mask = ~m;
        for (int i = 0; i < DIGITS; i++) begin
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_done_early"}, 32'(done), 32'd0);
            if (poke_start && i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_invalid"}, 32'(invalid), 32'(ei));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
        chk({tag, "_cout_hold"}, 32'(cout), 32'(ec));
        if (poke_start) begin
            repeat (DIGITS + 2) @(posedge clk);
            #1;
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        end
        chk({tag, "_done_count"}, 32'(done_cnt - cnt0), 32'd1);
    endtask

    initial begin
        int cnt_r;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; fault_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",   16'h1234, 16'h5678, 1'b0, 4'b0000, 16'h6912, 1'b0, 1'b0, 1'b0);
        run_op("wrap",    16'h9999, 16'h0001, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("cin_rip", 16'h0999, 16'h0000, 1'b1, 4'b0000, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("flt0",    16'h0005, 16'h0005, 1'b0, 4'b0001, 16'h000A, 1'b0, 1'b0, 1'b0);
        run_op("flt1",    16'h0005, 16'h0005, 1'b0, 4'b0010, 16'h0170, 1'b0, 1'b0, 1'b0);
        run_op("flt_all", 16'h0000, 16'h0000, 1'b0, 4'b1111, 16'h7776, 1'b1, 1'b0, 1'b0);
        run_op("inv",     16'h000F, 16'h0000, 1'b0, 4'b0000, 16'h0015, 1'b0, 1'b1, 1'b0);
        run_op("inv_clr", 16'h0001, 16'h0002, 1'b0, 4'b0000, 16'h0003, 1'b0, 1'b0, 1'b1);

        // Reset two cycles into RUN: partial sum is non-zero at that point.
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; cin = 1'b0; fault_mask = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt_r = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_sum_partial", 32'(sum), 32'h0098);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sum", 32'(sum), 32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        chk("mrst_invalid", 32'(invalid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_no_done", 32'(done_cnt - cnt_r), 32'd0);
        rst_n = 1'b1;
        run_op("post_rst", 16'h4321, 16'h1789, 1'b1, 4'b0000, 16'h6111, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
